// File: rtl/wave_frame_loader.sv
// Frame loader: checks the stream header, copies every frame word into the waveform buffer,
// and publishes the scan parameters. Define WAVE_FRAME_CHECKSUM_EN to verify word 13 against the payload sum.
module wave_frame_loader #(
  parameter int unsigned HDR_WORDS   = 14,
  parameter int unsigned ADDR_W      = 14,
  parameter logic [15:0] MAGIC       = 16'hA55A,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              gen_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [15:0]       xdata_points_number,
  output logic [15:0]       ydata_points_number,
  output logic [15:0]       cycles_per_points,
  output logic [15:0]       da_delay_cycles,
  output logic              data_rdy,
  output logic              frame_err,
  output logic [2:0]        err_code
);

  localparam int unsigned       TO_W         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST      = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [17:0]       HDR_LEN      = 18'(HDR_WORDS);
  localparam logic [17:0]       CAPACITY     = 18'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_YNUM     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IDX_LAST_HDR = ADDR_W'(HDR_WORDS - 1);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECK, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] widx, waddr;
  logic [16:0]       pcnt, pay_len;
  logic [TO_W-1:0]   idle_cnt;
  logic [15:0]       x_sh, y_sh, cpp_sh, dly_sh;
  logic [17:0]       frame_len;
  logic              beat, timed_out, len_bad;
  logic              do_write, err_set, rdy_set;
  logic [2:0]        err_val;
`ifdef WAVE_FRAME_CHECKSUM_EN
  logic [15:0]       chk_sh, sum;
`endif

  assign beat      = s_valid & s_ready;
  assign waddr     = (state == IDLE) ? '0 : widx;
  assign pay_len   = {1'b0, x_sh} + {1'b0, y_sh};
  assign frame_len = HDR_LEN + {2'b00, x_sh} + {2'b00, s_data};
  assign len_bad   = (x_sh == '0) || (s_data == '0) || (frame_len > CAPACITY);
  // idle_cnt holds cycles elapsed since the last beat, so the error lands TIMEOUT_CYC cycles after it
  assign timed_out = (idle_cnt == TO_LAST);

  always_comb begin
    s_ready = 1'b0;
    case (state)
      IDLE:            s_ready = ~gen_busy;
      HEADER, PAYLOAD: s_ready = 1'b1;
      default:         s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    err_set   = 1'b0;
    err_val   = '0;
    rdy_set   = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          if (s_data == MAGIC) begin
            do_write  = 1'b1;
            state_nxt = HEADER;
          end else begin
            err_set = 1'b1;
            err_val = 3'd1;
          end
        end
      end
      HEADER: begin
        if (beat) begin
          do_write = 1'b1;
          if (widx == IDX_YNUM && len_bad) begin
            err_set   = 1'b1;
            err_val   = 3'd2;
            state_nxt = IDLE;
          end else if (widx == IDX_LAST_HDR) begin
            state_nxt = PAYLOAD;
          end
        end else if (timed_out) begin
          err_set   = 1'b1;
          err_val   = 3'd3;
          state_nxt = IDLE;
        end
      end
      PAYLOAD: begin
        if (beat) begin
          do_write = 1'b1;
          if (pcnt + 17'd1 == pay_len) state_nxt = CHECK;
        end else if (timed_out) begin
          err_set   = 1'b1;
          err_val   = 3'd3;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
`ifdef WAVE_FRAME_CHECKSUM_EN
        if (sum != chk_sh) begin
          err_set   = 1'b1;
          err_val   = 3'd4;
          state_nxt = IDLE;
        end else begin
          rdy_set   = 1'b1;
          state_nxt = DONE;
        end
`else
        rdy_set   = 1'b1;
        state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      widx      <= '0;
      frame_err <= 1'b0;
      err_code  <= '0;
      data_rdy  <= 1'b0;
    end else begin
      wr_en     <= do_write;
      frame_err <= err_set;
      data_rdy  <= rdy_set;
      if (do_write) begin
        wr_addr <= waddr;
        wr_data <= s_data;
        widx    <= waddr + 1'b1;
      end
      if (err_set) err_code <= err_val;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      pcnt     <= '0;
    end else begin
      if (beat)
        idle_cnt <= TO_W'(1);
      else if (state == HEADER || state == PAYLOAD)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
      if (state == HEADER)
        pcnt <= '0;
      else if (state == PAYLOAD && beat)
        pcnt <= pcnt + 17'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_sh   <= '0;
      y_sh   <= '0;
      cpp_sh <= '0;
      dly_sh <= '0;
    end else if (state == HEADER && beat) begin
      if (widx == ADDR_W'(1)) x_sh   <= s_data;
      if (widx == ADDR_W'(2)) y_sh   <= s_data;
      if (widx == ADDR_W'(3)) cpp_sh <= s_data;
      if (widx == ADDR_W'(4)) dly_sh <= s_data;
    end
  end

`ifdef WAVE_FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chk_sh <= '0;
      sum    <= '0;
    end else begin
      if (state == HEADER && beat && widx == IDX_LAST_HDR) chk_sh <= s_data;
      if (state == HEADER)
        sum <= '0;
      else if (state == PAYLOAD && beat)
        sum <= sum + s_data;
    end
  end
`endif

  // Parameter outputs move only when a frame is accepted, so rejected frames leave them intact
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xdata_points_number <= '0;
      ydata_points_number <= '0;
      cycles_per_points   <= '0;
      da_delay_cycles     <= '0;
    end else if (rdy_set) begin
      xdata_points_number <= x_sh;
      ydata_points_number <= y_sh;
      cycles_per_points   <= cpp_sh;
      da_delay_cycles     <= dly_sh;
    end
  end

endmodule

// File: tb/tb_wave_frame_loader.sv
// Randomized bench for wave_frame_loader: a frame-position reference model predicts every output
// each cycle, and literal expectations from hand-built frames pin the model.
module tb_wave_frame_loader;

  localparam int          TO    = 100;
  localparam int          HDR   = 14;
  localparam int          CAP   = 16384;
  localparam logic [15:0] MAGIC = 16'hA55A;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        gen_busy;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] xdata_points_number, ydata_points_number, cycles_per_points, da_delay_cycles;
  logic        data_rdy, frame_err;
  logic [2:0]  err_code;

  wave_frame_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .gen_busy(gen_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .xdata_points_number(xdata_points_number), .ydata_points_number(ydata_points_number),
    .cycles_per_points(cycles_per_points), .da_delay_cycles(da_delay_cycles),
    .data_rdy(data_rdy), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position of the next expected word in the frame (-1 = hunting for MAGIC)
  int          m_pos, m_tail, m_idle, m_xn, m_yn;
  logic [15:0] m_cpp, m_dly, m_chk, m_sum;
  logic        e_wr_en, e_err, e_rdy;
  int          e_wr_addr;
  logic [15:0] e_wr_data, e_x, e_y, e_c, e_d;
  logic [2:0]  e_code;

  function automatic logic model_ready();
    return (m_pos >= 0) || (m_tail == 0 && !gen_busy);
  endfunction

  task automatic model_reset();
    m_pos = -1; m_tail = 0; m_idle = 0; m_xn = 0; m_yn = 0;
    m_cpp = '0; m_dly = '0; m_chk = '0; m_sum = '0;
    e_wr_en = 0; e_err = 0; e_rdy = 0; e_wr_addr = 0; e_wr_data = '0;
    e_x = '0; e_y = '0; e_c = '0; e_d = '0; e_code = '0;
  endtask

  task automatic emit_write(input int addr);
    e_wr_en = 1; e_wr_addr = addr; e_wr_data = s_data;
  endtask

  task automatic model_step();
    logic beat;
    beat = s_valid && model_ready();
    e_wr_en = 0; e_err = 0; e_rdy = 0;
    if (m_tail == 2) begin
      m_tail = 1;
`ifdef WAVE_FRAME_CHECKSUM_EN
      if (m_sum != m_chk) begin
        e_err = 1; e_code = 3'd4; m_tail = 0;
      end else
`endif
      begin
        e_rdy = 1; e_x = 16'(m_xn); e_y = 16'(m_yn); e_c = m_cpp; e_d = m_dly;
      end
    end else if (m_tail == 1) begin
      m_tail = 0;
    end else if (m_pos < 0) begin
      if (beat) begin
        if (s_data == MAGIC) begin
          emit_write(0); m_pos = 1; m_idle = 0; m_sum = '0;
        end else begin
          e_err = 1; e_code = 3'd1;
        end
      end
    end else if (beat) begin
      emit_write(m_pos);
      m_idle = 0;
      case (m_pos)
        1:  m_xn  = int'(s_data);
        2:  m_yn  = int'(s_data);
        3:  m_cpp = s_data;
        4:  m_dly = s_data;
        13: m_chk = s_data;
        default: ;
      endcase
      if (m_pos >= HDR) m_sum = m_sum + s_data;
      if (m_pos == 2 && (m_xn == 0 || m_yn == 0 || HDR + m_xn + m_yn > CAP)) begin
        e_err = 1; e_code = 3'd2; m_pos = -1;
      end else begin
        m_pos++;
        if (m_pos == HDR + m_xn + m_yn) begin
          m_pos = -1; m_tail = 2;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TO - 1) begin
        e_err = 1; e_code = 3'd3; m_pos = -1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    check("s_ready", s_ready, model_ready());
    check("wr_en", wr_en, e_wr_en);
    if (e_wr_en) begin
      check("wr_addr", wr_addr, e_wr_addr);
      check("wr_data", wr_data, e_wr_data);
    end
    check("frame_err", frame_err, e_err);
    check("data_rdy", data_rdy, e_rdy);
    check("err_code", err_code, e_code);
    check("xnum_out", xdata_points_number, e_x);
    check("ynum_out", ydata_points_number, e_y);
    check("cpp_out", cycles_per_points, e_c);
    check("delay_out", da_delay_cycles, e_d);
  end

  // Event monitor for the hand-computed expectations (cycle numbers count from the beat edge)
  int n_wr = 0, n_rdy = 0, n_ferr = 0, rdy_cyc = 0, ferr_cyc = 0, last_wr_addr = 0;
  initial forever begin
    @(negedge clk);
    if (wr_en) begin n_wr++; last_wr_addr = int'(wr_addr); end
    if (data_rdy) begin n_rdy++; rdy_cyc = cyc + 1; end
    if (frame_err) begin n_ferr++; ferr_cyc = cyc + 1; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  logic [15:0] fq[$];
  int last_beat_cyc = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic build(input int xn, input int yn, input logic [15:0] cpp, input logic [15:0] dly,
                       input bit plain, input logic [15:0] chk_adj);
    logic [15:0] pay[$];
    logic [15:0] s;
    logic [15:0] w;
    s = '0;
    fq.delete();
    for (int i = 0; i < xn + yn; i++) begin
      w = plain ? 16'(i + 1) : 16'($urandom);
      pay.push_back(w);
      s = s + w;
    end
    fq.push_back(MAGIC); fq.push_back(16'(xn)); fq.push_back(16'(yn));
    fq.push_back(cpp); fq.push_back(dly);
    for (int i = 0; i < 8; i++) fq.push_back(plain ? 16'h0000 : 16'($urandom));
    fq.push_back(s + chk_adj);
    foreach (pay[i]) fq.push_back(pay[i]);
  endtask

  task automatic send_frame(input int n, input int max_gap, input int busy_at);
    logic acc;
    int   waited;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) tick(int'($urandom_range(0, max_gap)));
      s_valid = 1'b1;
      s_data  = fq[i];
      if (i == busy_at) gen_busy = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 300) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #2;
        waited++;
      end
      s_valid = 1'b0;
      if (!acc) begin
        n_checks++; n_errors++;
        $display("FAIL handshake: word %0d got no s_ready within %0d cycles, expected acceptance", i, waited);
        return;
      end
      last_beat_cyc = cyc;
    end
  endtask

  int          wr0, rdy0, ferr0, kind, busy_at;
  logic [15:0] junk, adj;

  initial begin
    s_valid = 1'b0; s_data = '0; gen_busy = 1'b0;
    #1 rstn = 1'b0;
    tick(3);
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_params", {xdata_points_number, ydata_points_number}, 0);
    check("reset_err_code", err_code, 0);
    rstn = 1'b1;
    tick(2);

    // Reference frame: 20 words, payload 1..6, checksum 0x0015
    wr0 = n_wr; rdy0 = n_rdy; ferr0 = n_ferr;
    build(4, 2, 16'd10, 16'd3, 1'b1, 16'h0000);
    check("ref_chk_word", fq[13], 16'h0015);
    send_frame(fq.size(), 0, -1);
    tick(4);
    check("good_writes", n_wr - wr0, 20);
    check("good_last_addr", last_wr_addr, 19);
    check("good_rdy_count", n_rdy - rdy0, 1);
    check("good_rdy_latency", rdy_cyc - last_beat_cyc, 2);
    check("good_no_err", n_ferr - ferr0, 0);
    check("good_xnum", xdata_points_number, 4);
    check("good_ynum", ydata_points_number, 2);
    check("good_cpp", cycles_per_points, 10);
    check("good_delay", da_delay_cycles, 3);

    // Bad magic then a good frame
    wr0 = n_wr; rdy0 = n_rdy; ferr0 = n_ferr;
    fq = {16'h1234};
    send_frame(1, 0, -1);
    tick(2);
    check("magic_err_count", n_ferr - ferr0, 1);
    check("magic_err_code", err_code, 1);
    check("magic_no_write", n_wr - wr0, 0);
    build(4, 2, 16'd10, 16'd3, 1'b1, 16'h0000);
    send_frame(fq.size(), 0, -1);
    tick(4);
    check("resync_rdy", n_rdy - rdy0, 1);
    check("resync_writes", n_wr - wr0, 20);

    // Oversized frame, then zero xnum
    ferr0 = n_ferr;
    fq = {MAGIC, 16'd16380, 16'd10};
    send_frame(3, 0, -1);
    tick(2);
    check("len_err_count", n_ferr - ferr0, 1);
    check("len_err_code", err_code, 2);
    check("len_err_latency", ferr_cyc - last_beat_cyc, 1);
    fq = {MAGIC, 16'd0, 16'd5};
    send_frame(3, 0, -1);
    tick(2);
    check("zero_x_err_count", n_ferr - ferr0, 2);
    check("zero_x_err_code", err_code, 2);
    rdy0 = n_rdy;
    build(4, 2, 16'd10, 16'd3, 1'b1, 16'h0000);
    send_frame(fq.size(), 0, -1);
    tick(4);
    check("after_len_rdy", n_rdy - rdy0, 1);

    // Stall after 7 payload words
    rdy0 = n_rdy; ferr0 = n_ferr;
    build(8, 4, 16'd77, 16'd88, 1'b0, 16'h0000);
    send_frame(HDR + 7, 0, -1);
    tick(TO + 10);
    check("timeout_err_count", n_ferr - ferr0, 1);
    check("timeout_err_code", err_code, 3);
    check("timeout_latency", ferr_cyc - last_beat_cyc, TO);
    check("timeout_no_rdy", n_rdy - rdy0, 0);
    check("timeout_xnum_kept", xdata_points_number, 4);
    check("timeout_cpp_kept", cycles_per_points, 10);

    // gen_busy blocks the start of a frame but not one in flight
    wr0 = n_wr; rdy0 = n_rdy; ferr0 = n_ferr;
    gen_busy = 1'b1; s_valid = 1'b1; s_data = MAGIC;
    tick(5);
    check("busy_s_ready", s_ready, 0);
    check("busy_no_write", n_wr - wr0, 0);
    s_valid = 1'b0; gen_busy = 1'b0;
    build(5, 3, 16'd21, 16'd22, 1'b0, 16'h0000);
    send_frame(fq.size(), 1, 16);
    tick(4);
    gen_busy = 1'b0;
    check("busy_mid_rdy", n_rdy - rdy0, 1);
    check("busy_mid_no_err", n_ferr - ferr0, 0);
    check("busy_mid_xnum", xdata_points_number, 5);

    // Checksum off by one (0x0014)
    rdy0 = n_rdy; ferr0 = n_ferr;
    build(4, 2, 16'd10, 16'd3, 1'b1, 16'hFFFF);
    send_frame(fq.size(), 0, -1);
    tick(4);
`ifdef WAVE_FRAME_CHECKSUM_EN
    check("chk_bad_no_rdy", n_rdy - rdy0, 0);
    check("chk_bad_err", n_ferr - ferr0, 1);
    check("chk_bad_code", err_code, 4);
`else
    check("chk_ignored_rdy", n_rdy - rdy0, 1);
    check("chk_ignored_no_err", n_ferr - ferr0, 0);
`endif

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        junk = 16'($urandom);
        if (junk == MAGIC) junk = 16'h0000;
        fq = {junk};
        send_frame(1, 2, -1);
      end else if (kind == 1) begin
        fq = {MAGIC, 16'($urandom_range(0, 3)), 16'h0000};
        send_frame(3, 2, -1);
      end else begin
        adj = 16'h0000;
`ifdef WAVE_FRAME_CHECKSUM_EN
        if ($urandom_range(0, 4) == 0) adj = 16'h0001;
`endif
        build(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
              16'($urandom), 16'($urandom), 1'b0, adj);
        busy_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, fq.size() - 1)) : -1;
        send_frame(fq.size(), int'($urandom_range(0, 3)), busy_at);
      end
      tick(3);
      gen_busy = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        gen_busy = 1'b1; s_valid = 1'b1; s_data = 16'($urandom);
        tick(int'($urandom_range(1, 4)));
        s_valid = 1'b0; gen_busy = 1'b0;
      end
    end

    // Reset mid-frame clears parameters; the next frame loads from address 0
    build(6, 6, 16'd5, 16'd6, 1'b0, 16'h0000);
    send_frame(10, 0, -1);
    rstn = 1'b0;
    tick(1);
    check("midrst_xnum", xdata_points_number, 0);
    check("midrst_wr_en", wr_en, 0);
    tick(1);
    rstn = 1'b1;
    tick(1);
    rdy0 = n_rdy;
    build(4, 2, 16'd10, 16'd3, 1'b1, 16'h0000);
    send_frame(fq.size(), 0, -1);
    tick(4);
    check("post_rst_rdy", n_rdy - rdy0, 1);
    check("post_rst_last_addr", last_wr_addr, 19);
    check("post_rst_delay", da_delay_cycles, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
